// File: rtl/ide_sector_if.sv
// ide_sector_if: bundles the two buses driven by the sector sequencer.
//   ATA side   : ata_rd/ata_wr requests, ata_addr {cs[1:0],da[2:0]}, ata_wdata,
//                ata_rdata (valid with ata_done), ata_done (1-cycle completion).
//   Buffer side: buf_addr word index, buf_we/buf_wdata write port,
//                buf_rdata synchronous read data (valid 1 cycle after buf_addr).
// master = the sequencer, slave = the ide stage plus the sector buffer RAM.
interface ide_sector_if;
  logic        ata_rd;
  logic        ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_wdata;
  logic [15:0] ata_rdata;
  logic        ata_done;
  logic [7:0]  buf_addr;
  logic        buf_we;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata;

  modport master (
    output ata_rd, ata_wr, ata_addr, ata_wdata,
    input  ata_rdata, ata_done,
    output buf_addr, buf_we, buf_wdata,
    input  buf_rdata
  );

  modport slave (
    input  ata_rd, ata_wr, ata_addr, ata_wdata,
    output ata_rdata, ata_done,
    input  buf_addr, buf_we, buf_wdata,
    output buf_rdata
  );
endinterface

// File: rtl/ide_sector.sv
// ide_sector: single-sector LBA28 ATA PIO read/write sequencer.
// Issues task-file writes, the command, status polls and a 256-word data
// transfer through the ide register-cycle stage, moving data to/from a
// 256x16 synchronous buffer RAM.
// Ports:
//   clk, reset (async, active-low)
//   start/write/lba : request (write and lba sampled with start)
//   busy, done, err, status : progress and result
//   bus (ide_sector_if.master) : ATA access requests and buffer RAM port
module ide_sector #(
  parameter logic [19:0] POLL_MAX  = 20'hFFFFF,
  parameter logic [7:0]  CMD_READ  = 8'h20,
  parameter logic [7:0]  CMD_WRITE = 8'h30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         write,
  input  logic [27:0]  lba,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [7:0]   status,
  ide_sector_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WRDY = 4'd1,
    ST_SCNT = 4'd2,
    ST_SL0  = 4'd3,
    ST_SL1  = 4'd4,
    ST_SL2  = 4'd5,
    ST_SDEV = 4'd6,
    ST_SCMD = 4'd7,
    ST_WDRQ = 4'd8,
    ST_XFER = 4'd9,
    ST_WBSY = 4'd10,
    ST_FIN  = 4'd11
  } state_t;

  localparam logic [4:0] REG_DATA   = 5'h10;
  localparam logic [4:0] REG_STATUS = 5'h17;

  // registered state and outputs
  state_t      state_r;
  logic        wr_op_r;
  logic [27:0] lba_r;
  logic [7:0]  idx_r;
  logic [19:0] cnt_r;
  logic        pre_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [7:0]  status_r;
  logic        ata_rd_r;
  logic        ata_wr_r;
  logic [4:0]  ata_addr_r;
  logic [15:0] ata_wdata_r;
  logic [7:0]  buf_addr_r;
  logic        buf_we_r;
  logic [15:0] buf_wdata_r;

  // next-state values
  state_t      state_s;
  logic        wr_op_s;
  logic [27:0] lba_s;
  logic [7:0]  idx_s;
  logic [19:0] cnt_s;
  logic        pre_s;
  logic        busy_s;
  logic        done_s;
  logic        err_s;
  logic [7:0]  status_s;
  logic        ata_rd_s;
  logic        ata_wr_s;
  logic [4:0]  ata_addr_s;
  logic [15:0] ata_wdata_s;
  logic [7:0]  buf_addr_s;
  logic        buf_we_s;
  logic [15:0] buf_wdata_s;

  // access launch request and helpers
  logic        go_s;
  logic        go_wr_s;
  logic [4:0]  go_addr_s;
  logic [15:0] go_data_s;
  logic        fin_s;
  logic        req_s;
  logic        acc_end_s;
  logic [7:0]  stat_s;
  logic        poll_last_s;

  // task-file register decode
  logic [2:0]  tf_reg_s;
  logic [7:0]  tf_val_s;
  state_t      tf_next_s;

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign status        = status_r;
  assign bus.ata_rd    = ata_rd_r;
  assign bus.ata_wr    = ata_wr_r;
  assign bus.ata_addr  = ata_addr_r;
  assign bus.ata_wdata = ata_wdata_r;
  assign bus.buf_addr  = buf_addr_r;
  assign bus.buf_we    = buf_we_r;
  assign bus.buf_wdata = buf_wdata_r;

  // Task-file register number, value and successor for the setup states.
  always_comb begin
    tf_reg_s  = 3'd2;
    tf_val_s  = 8'h00;
    tf_next_s = ST_IDLE;
    case (state_r)
      ST_SCNT: begin tf_reg_s = 3'd2; tf_val_s = 8'h01;               tf_next_s = ST_SL0;  end
      ST_SL0:  begin tf_reg_s = 3'd3; tf_val_s = lba_r[7:0];          tf_next_s = ST_SL1;  end
      ST_SL1:  begin tf_reg_s = 3'd4; tf_val_s = lba_r[15:8];         tf_next_s = ST_SL2;  end
      ST_SL2:  begin tf_reg_s = 3'd5; tf_val_s = lba_r[23:16];        tf_next_s = ST_SDEV; end
      ST_SDEV: begin tf_reg_s = 3'd6; tf_val_s = {4'hE, lba_r[27:24]}; tf_next_s = ST_SCMD; end
      ST_SCMD: begin
        tf_reg_s  = 3'd7;
        tf_val_s  = wr_op_r ? CMD_WRITE : CMD_READ;
        tf_next_s = ST_WDRQ;
      end
      default: begin
        tf_reg_s  = 3'd2;
        tf_val_s  = 8'h00;
        tf_next_s = ST_IDLE;
      end
    endcase
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s     = state_r;
    wr_op_s     = wr_op_r;
    lba_s       = lba_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    pre_s       = pre_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = err_r;
    status_s    = status_r;
    ata_rd_s    = ata_rd_r;
    ata_wr_s    = ata_wr_r;
    ata_addr_s  = ata_addr_r;
    ata_wdata_s = ata_wdata_r;
    buf_addr_s  = buf_addr_r;
    buf_we_s    = 1'b0;
    buf_wdata_s = buf_wdata_r;
    go_s        = 1'b0;
    go_wr_s     = 1'b0;
    go_addr_s   = 5'h00;
    go_data_s   = 16'h0000;
    fin_s       = 1'b0;

    // A request stays up until ata_done; when it is low in an access state
    // we are in the mandatory idle cycle and launch the next access.
    req_s       = ata_rd_r | ata_wr_r;
    acc_end_s   = req_s & bus.ata_done;
    stat_s      = bus.ata_rdata[7:0];
    poll_last_s = (cnt_r == (POLL_MAX - 20'd1));

    if (acc_end_s) begin
      ata_rd_s = 1'b0;
      ata_wr_s = 1'b0;
    end else begin
      ata_rd_s = ata_rd_r;
      ata_wr_s = ata_wr_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          wr_op_s   = write;
          lba_s     = lba;
          err_s     = 1'b0;
          busy_s    = 1'b1;
          cnt_s     = 20'd0;
          idx_s     = 8'd0;
          go_s      = 1'b1;
          go_addr_s = REG_STATUS;
          state_s   = ST_WRDY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRDY: begin
        if (acc_end_s) begin
          status_s = stat_s;
          if (!stat_s[7] && stat_s[6]) begin
            state_s = ST_SCNT;
          end else if (poll_last_s) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 20'd1;
          end
        end else if (!req_s) begin
          go_s      = 1'b1;
          go_addr_s = REG_STATUS;
        end else begin
          state_s = ST_WRDY;
        end
      end

      ST_SCNT, ST_SL0, ST_SL1, ST_SL2, ST_SDEV, ST_SCMD: begin
        if (acc_end_s) begin
          state_s = tf_next_s;
          cnt_s   = 20'd0;
        end else if (!req_s) begin
          go_s      = 1'b1;
          go_wr_s   = 1'b1;
          go_addr_s = {2'b10, tf_reg_s};
          go_data_s = {8'h00, tf_val_s};
        end else begin
          state_s = state_r;
        end
      end

      ST_WDRQ: begin
        if (acc_end_s) begin
          status_s = stat_s;
          if (!stat_s[7] && stat_s[3]) begin
            state_s    = ST_XFER;
            idx_s      = 8'd0;
            buf_addr_s = 8'd0;
            pre_s      = 1'b0;
          end else if (!stat_s[7] && stat_s[0]) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else if (poll_last_s) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 20'd1;
          end
        end else if (!req_s) begin
          go_s      = 1'b1;
          go_addr_s = REG_STATUS;
        end else begin
          state_s = ST_WDRQ;
        end
      end

      ST_XFER: begin
        if (acc_end_s) begin
          if (!wr_op_r) begin
            buf_we_s    = 1'b1;
            buf_wdata_s = bus.ata_rdata;
            buf_addr_s  = idx_r;
          end else begin
            // present the next word's address now so the RAM output is
            // ready before the next write is launched
            buf_addr_s = idx_r + 8'd1;
          end
          if (idx_r == 8'd255) begin
            idx_s = 8'd0;
            if (wr_op_r) begin
              state_s = ST_WBSY;
              cnt_s   = 20'd0;
            end else begin
              fin_s = 1'b1;
            end
          end else begin
            idx_s = idx_r + 8'd1;
          end
        end else if (!req_s) begin
          if (!wr_op_r) begin
            go_s      = 1'b1;
            go_addr_s = REG_DATA;
          end else if (!pre_r) begin
            // buffer read latency: wait one cycle for buf_rdata
            pre_s = 1'b1;
          end else begin
            pre_s     = 1'b0;
            go_s      = 1'b1;
            go_wr_s   = 1'b1;
            go_addr_s = REG_DATA;
            go_data_s = bus.buf_rdata;
          end
        end else begin
          state_s = ST_XFER;
        end
      end

      ST_WBSY: begin
        if (acc_end_s) begin
          status_s = stat_s;
          if (!stat_s[7]) begin
            err_s = stat_s[0];
            fin_s = 1'b1;
          end else if (poll_last_s) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 20'd1;
          end
        end else if (!req_s) begin
          go_s      = 1'b1;
          go_addr_s = REG_STATUS;
        end else begin
          state_s = ST_WBSY;
        end
      end

      ST_FIN: begin
        // done is already high this cycle; start is ignored here
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase

    if (fin_s) begin
      state_s = ST_FIN;
      done_s  = 1'b1;
      busy_s  = 1'b0;
    end else begin
      done_s = 1'b0;
    end

    if (go_s) begin
      ata_rd_s    = ~go_wr_s;
      ata_wr_s    = go_wr_s;
      ata_addr_s  = go_addr_s;
      ata_wdata_s = go_data_s;
    end else begin
      ata_addr_s  = ata_addr_r;
      ata_wdata_s = ata_wdata_r;
    end
  end

  // State and output registers; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wr_op_r     <= 1'b0;
      lba_r       <= 28'd0;
      idx_r       <= 8'd0;
      cnt_r       <= 20'd0;
      pre_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      status_r    <= 8'h00;
      ata_rd_r    <= 1'b0;
      ata_wr_r    <= 1'b0;
      ata_addr_r  <= 5'h00;
      ata_wdata_r <= 16'h0000;
      buf_addr_r  <= 8'h00;
      buf_we_r    <= 1'b0;
      buf_wdata_r <= 16'h0000;
    end else begin
      state_r     <= state_s;
      wr_op_r     <= wr_op_s;
      lba_r       <= lba_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      pre_r       <= pre_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      status_r    <= status_s;
      ata_rd_r    <= ata_rd_s;
      ata_wr_r    <= ata_wr_s;
      ata_addr_r  <= ata_addr_s;
      ata_wdata_r <= ata_wdata_s;
      buf_addr_r  <= buf_addr_s;
      buf_we_r    <= buf_we_s;
      buf_wdata_r <= buf_wdata_s;
    end
  end

endmodule

// File: tb/tb_ide_sector.sv
// tb_ide_sector: table-driven bench for ide_sector. Two instances share a
// behavioural ide/drive model and buffer RAM: dut_a uses the default poll
// limit, dut_b uses POLL_MAX=16. sel chooses which instance the model serves.
module tb_ide_sector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_a, start_b, write;
  logic [27:0] lba;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [7:0]  status_a, status_b;

  ide_sector_if if_a ();
  ide_sector_if if_b ();

  ide_sector dut_a (
    .clk(clk), .reset(reset), .start(start_a), .write(write), .lba(lba),
    .busy(busy_a), .done(done_a), .err(err_a), .status(status_a), .bus(if_a)
  );

  ide_sector #(.POLL_MAX(20'd16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .write(write), .lba(lba),
    .busy(busy_b), .done(done_b), .err(err_b), .status(status_b), .bus(if_b)
  );

  logic        sel;
  logic        m_rd, m_wr, m_bwe, s_busy, s_done, s_err;
  logic [4:0]  m_addr;
  logic [15:0] m_wdata, m_bwdata;
  logic [7:0]  m_baddr, s_status;
  assign m_rd     = sel ? if_b.ata_rd    : if_a.ata_rd;
  assign m_wr     = sel ? if_b.ata_wr    : if_a.ata_wr;
  assign m_addr   = sel ? if_b.ata_addr  : if_a.ata_addr;
  assign m_wdata  = sel ? if_b.ata_wdata : if_a.ata_wdata;
  assign m_baddr  = sel ? if_b.buf_addr  : if_a.buf_addr;
  assign m_bwe    = sel ? if_b.buf_we    : if_a.buf_we;
  assign m_bwdata = sel ? if_b.buf_wdata : if_a.buf_wdata;
  assign s_busy   = sel ? busy_b   : busy_a;
  assign s_done   = sel ? done_b   : done_a;
  assign s_err    = sel ? err_b    : err_a;
  assign s_status = sel ? status_b : status_a;

  // ---------------- ide + drive model ----------------
  logic        clr;
  int          lat, bsy, bsy2, mode, pre_mode;
  logic        mdl_done = 1'b0;
  logic [15:0] mdl_rdata = 16'h0000;
  logic        gap_chk = 1'b0;
  int          age = 0, sreads = 0, pre_n = 0, post_n = 0, dcnt = 0, tf_n = 0;
  int          first_tf_at = 0, viol = 0;
  logic        cmd_seen = 1'b0;
  logic [4:0]  tf_addr [8];
  logic [15:0] tf_val [8];
  logic [15:0] drv_mem [256];
  logic [7:0]  st;

  assign if_a.ata_done  = mdl_done;
  assign if_b.ata_done  = mdl_done;
  assign if_a.ata_rdata = mdl_rdata;
  assign if_b.ata_rdata = mdl_rdata;

  function automatic logic [15:0] pat(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b ^ 8'h5A, b};
  endfunction

  // mode: 0 normal, 1 ERR after command, 2 stuck busy, 3 ERR after write data
  always_comb begin
    st = 8'h00;
    if (mode == 2)               st = 8'h80;
    else if (!cmd_seen)          st = (pre_n < bsy) ? 8'h80 : 8'h50;
    else if (dcnt >= 256)        st = (mode == 3) ? 8'h51 : 8'h50;
    else if (post_n < bsy2)      st = 8'h80;
    else                         st = (mode == 1) ? 8'h51 : 8'h58;
  end

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    gap_chk  <= mdl_done;
    viol     <= viol + ((gap_chk && (m_rd || m_wr)) ? 1 : 0) + ((m_rd && m_wr) ? 1 : 0);
    if (clr) begin
      age <= 0; sreads <= 0; pre_n <= 0; post_n <= 0; dcnt <= 0; tf_n <= 0;
      first_tf_at <= -1; cmd_seen <= 1'b0; viol <= 0;
      for (int i = 0; i < 256; i++) drv_mem[i] <= 16'h0000;
    end else if ((m_rd || m_wr) && !mdl_done) begin
      if (age >= lat - 1) begin
        age      <= 0;
        mdl_done <= 1'b1;
        if (m_rd && m_addr == 5'h17) begin
          sreads    <= sreads + 1;
          mdl_rdata <= {8'h00, st};
          if (!cmd_seen) pre_n <= pre_n + 1;
          else           post_n <= post_n + 1;
        end else if (m_rd && m_addr == 5'h10) begin
          mdl_rdata <= pat(dcnt);
          dcnt      <= dcnt + 1;
        end else if (m_wr && m_addr == 5'h10) begin
          if (dcnt < 256) drv_mem[dcnt] <= m_wdata;
          dcnt <= dcnt + 1;
        end else if (m_wr) begin
          if (tf_n < 8) begin
            tf_addr[tf_n] <= m_addr;
            tf_val[tf_n]  <= m_wdata;
          end
          if (tf_n == 0) first_tf_at <= sreads;
          tf_n <= tf_n + 1;
          if (m_addr == 5'h17) cmd_seen <= 1'b1;
        end else begin
          mdl_rdata <= 16'hFFFF;
        end
      end else begin
        age <= age + 1;
      end
    end else begin
      age <= 0;
    end
  end

  // ---------------- sector buffer RAM ----------------
  logic [15:0] bufmem [256];
  logic [15:0] ram_q = 16'h0000;
  int          we_cnt = 0;
  assign if_a.buf_rdata = ram_q;
  assign if_b.buf_rdata = ram_q;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++)
        bufmem[i] <= (pre_mode == 1) ? (i[15:0] ^ 16'hA5A5) : 16'hDEAD;
      we_cnt <= 0;
    end else if (m_bwe) begin
      bufmem[m_baddr] <= m_bwdata;
      we_cnt <= we_cnt + 1;
    end
    ram_q <= bufmem[m_baddr];
  end

  int dca = 0;
  always @(posedge clk) if (done_a) dca <= dca + 1;

  // ---------------- checking ----------------
  int tests = 0, fails = 0, cur_vec = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, cur_vec, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        wr;
    logic [27:0] lba;
    int          bsy;
    int          bsy2;
    int          mode;
    logic        poke;
    logic        exp_err;
    logic [7:0]  exp_status;
    int          exp_sreads;
    int          exp_tf;
    int          exp_data;
    int          exp_we;
  } vec_t;

  vec_t tbl [9];

  task automatic run_vec(input vec_t v, input int n);
    logic        got;
    int          bad;
    logic [7:0]  ev [6];
    sel = v.sel; bsy = v.bsy; bsy2 = v.bsy2; mode = v.mode;
    lat = 1 + (n % 3);
    pre_mode = v.wr ? 1 : 0;
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    write = v.wr; lba = v.lba;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; start_b = 1'b0;
    check("start_to_rd", {61'd0, s_busy, m_rd, m_wr}, 64'd6);
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(posedge clk); #1;
      if (s_done) got = 1'b1;
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("err", {63'd0, s_err}, {63'd0, v.exp_err});
    check("status", {56'd0, s_status}, {56'd0, v.exp_status});
    if (v.poke) begin
      if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    end
    @(posedge clk); #1 start_a = 1'b0; start_b = 1'b0;
    check("done_pulse_idle", {61'd0, s_done, s_busy, m_rd | m_wr}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("err_hold", {63'd0, s_err}, {63'd0, v.exp_err});
    check("status_reads", sreads, v.exp_sreads);
    check("taskfile_writes", tf_n, v.exp_tf);
    check("data_accesses", dcnt, v.exp_data);
    check("buf_we_count", we_cnt, v.exp_we);
    check("protocol_viol", viol, 0);
    if (v.exp_tf == 6) begin
      ev[0] = 8'h01; ev[1] = v.lba[7:0]; ev[2] = v.lba[15:8]; ev[3] = v.lba[23:16];
      ev[4] = {4'hE, v.lba[27:24]}; ev[5] = v.wr ? 8'h30 : 8'h20;
      bad = 0;
      for (int k = 0; k < 6; k++)
        if (tf_addr[k] !== (5'h12 + k[4:0]) || tf_val[k] !== {8'h00, ev[k]}) bad++;
      check("taskfile_content", bad, 0);
      check("first_tf_after_polls", first_tf_at, v.bsy + 1);
    end
    if (v.exp_we == 256) begin
      bad = 0;
      for (int k = 0; k < 256; k++) if (bufmem[k] !== pat(k)) bad++;
      check("read_buffer_data", bad, 0);
    end
    if (v.wr && v.exp_data == 256) begin
      bad = 0;
      for (int k = 0; k < 256; k++) if (drv_mem[k] !== (k[15:0] ^ 16'hA5A5)) bad++;
      check("write_drive_data", bad, 0);
    end
  endtask

  initial begin
    logic got;
    int   d0;
    vec_t rv;
    start_a = 1'b0; start_b = 1'b0; write = 1'b0; lba = 28'd0; sel = 1'b0;
    clr = 1'b0; lat = 1; bsy = 0; bsy2 = 0; mode = 0; pre_mode = 0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {busy_a, done_a, err_a, status_a, if_a.ata_rd, if_a.ata_wr, if_a.ata_addr,
                      if_a.ata_wdata, if_a.buf_addr, if_a.buf_we, if_a.buf_wdata}, 64'd0);
    check("reset_b", {busy_b, done_b, err_b, status_b, if_b.ata_rd, if_b.ata_wr, if_b.ata_addr,
                      if_b.ata_wdata, if_b.buf_addr, if_b.buf_we, if_b.buf_wdata}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    //          sel   wr    lba          bsy  bsy2 mode poke  err   status sreads tf data  we
    tbl[0] = '{1'b0, 1'b0, 28'h0123456, 0,   0,   0,   1'b0, 1'b0, 8'h58, 2,     6, 256, 256};
    tbl[1] = '{1'b0, 1'b1, 28'hFFFFFFF, 0,   0,   0,   1'b1, 1'b0, 8'h50, 3,     6, 256, 0};
    tbl[2] = '{1'b0, 1'b0, 28'h0000001, 100, 0,   0,   1'b0, 1'b0, 8'h58, 102,   6, 256, 256};
    tbl[3] = '{1'b0, 1'b0, 28'h0000800, 0,   0,   1,   1'b0, 1'b1, 8'h51, 2,     6, 0,   0};
    tbl[4] = '{1'b1, 1'b0, 28'h0000010, 0,   0,   2,   1'b0, 1'b1, 8'h80, 16,    0, 0,   0};
    tbl[5] = '{1'b1, 1'b1, 28'h0ABCDEF, 5,   0,   0,   1'b0, 1'b0, 8'h50, 8,     6, 256, 0};
    tbl[6] = '{1'b1, 1'b1, 28'h0000002, 0,   0,   1,   1'b0, 1'b1, 8'h51, 2,     6, 0,   0};
    tbl[7] = '{1'b0, 1'b1, 28'h0000003, 0,   0,   3,   1'b0, 1'b1, 8'h51, 3,     6, 256, 0};
    tbl[8] = '{1'b1, 1'b0, 28'h0000004, 10,  10,  0,   1'b0, 1'b0, 8'h58, 22,    6, 256, 256};

    for (int i = 0; i < 9; i++) begin
      cur_vec = i;
      run_vec(tbl[i], i);
    end

    // reset in the middle of a read transfer
    cur_vec = 100;
    sel = 1'b0; bsy = 0; bsy2 = 0; mode = 0; lat = 2; pre_mode = 0;
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    write = 1'b0; lba = 28'h0000100; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(posedge clk); #1;
      if (dcnt == 100) got = 1'b1;
    end
    check("reach_word_100", {63'd0, got}, 64'd1);
    d0 = dca;
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {busy_a, done_a, err_a, status_a, if_a.ata_rd, if_a.ata_wr,
                                if_a.ata_addr, if_a.ata_wdata, if_a.buf_addr, if_a.buf_we,
                                if_a.buf_wdata}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("no_done_after_reset", dca, d0);

    cur_vec = 101;
    rv = '{1'b0, 1'b0, 28'h0765432, 2, 0, 0, 1'b0, 1'b0, 8'h58, 4, 6, 256, 256};
    run_vec(rv, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
